// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_RX_TO_W = 8;

    typedef struct packed {
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO write strobe and show-ahead read port bundle.
interface uart_rx_fifo_if;

    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       frame_err_i;
    logic       parity_err_i;
    logic       rd_ready_i;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic       rd_frame_err_o;
    logic       rd_parity_err_o;

    // master: receiver + register-side consumer; slave: the FIFO
    modport master (
        output rx_valid_i, rx_data_i, frame_err_i, parity_err_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, rd_frame_err_o, rd_parity_err_o
    );

    modport slave (
        input  rx_valid_i, rx_data_i, frame_err_i, parity_err_i, rd_ready_i,
        output rd_valid_o, rd_data_o, rd_frame_err_o, rd_parity_err_o
    );

endinterface

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter: counts idle bit times while data waits, sticky flag.
module uart_rx_timeout
    import uart_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    nonempty_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    idle_i,
    input  logic                    tick_i,
    input  logic [UART_RX_TO_W-1:0] val_i,
    output logic                    timeout_o
);

    logic [UART_RX_TO_W-1:0] r_cnt;
    logic [UART_RX_TO_W-1:0] w_cnt_inc;
    logic                    r_to;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 8'd1;
    assign timeout_o = r_to;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else if (push_i || pop_i) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else if (!nonempty_i) begin
            r_cnt <= '0;
        end else if (val_i == '0) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else if (tick_i && idle_i && !r_to) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == val_i)
                r_to <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: flop storage, show-ahead read, watermark, overflow pulse.
// Character timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    uart_rx_fifo_if.slave           bus,
    input  logic                    rx_idle_i,
    input  logic                    tick_baud_i,
    input  logic                    clr_i,
    output logic [DW-1:0]           depth_o,
    input  logic [DW-1:0]           wm_lvl_i,
    output logic                    watermark_o,
    output logic                    overflow_o,
    input  logic [UART_RX_TO_W-1:0] timeout_val_i,
    output logic                    timeout_o
);

    localparam int AW = DW - 1;

    uart_rx_entry_t r_mem [DEPTH];
    logic [DW-1:0]  r_wptr, r_rptr;
    logic           r_ovf;
    logic           w_empty, w_full, w_pop, w_push, w_drop;
    uart_rx_entry_t w_head, w_in;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_pop   = !w_empty && bus.rd_ready_i;
    assign w_push  = bus.rx_valid_i && (!w_full || w_pop);
    assign w_drop  = bus.rx_valid_i && w_full && !w_pop;

    assign w_in = '{parity_err: bus.parity_err_i, frame_err: bus.frame_err_i, data: bus.rx_data_i};
    // Gate the head so every output reads 0 while empty (including out of reset)
    assign w_head = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    assign bus.rd_valid_o      = !w_empty;
    assign bus.rd_data_o       = w_head.data;
    assign bus.rd_frame_err_o  = w_head.frame_err;
    assign bus.rd_parity_err_o = w_head.parity_err;

    assign depth_o     = r_wptr - r_rptr;
    assign watermark_o = (wm_lvl_i != '0) && (depth_o >= wm_lvl_i);
    assign overflow_o  = r_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_ovf <= w_drop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i && !rst_i)
            r_mem[r_wptr[AW-1:0]] <= w_in;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_timeout u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .nonempty_i (!w_empty),
        .push_i     (w_push),
        .pop_i      (w_pop),
        .idle_i     (rx_idle_i),
        .tick_i     (tick_baud_i),
        .val_i      (timeout_val_i),
        .timeout_o  (timeout_o)
    );
`else
    logic w_unused;
    assign w_unused  = ^{rx_idle_i, tick_baud_i, timeout_val_i};
    assign timeout_o = 1'b0;
`endif

endmodule
